// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM slot scheduler: slot count and the
// per-slot {source, channel} selector carried in the runtime slot map.
package tdm_pkg;

  localparam int C_TDM_SLOTS = 8;
  localparam int C_SEL_W     = 3;
  localparam int C_MAP_W     = C_TDM_SLOTS * C_SEL_W;

  typedef struct packed {
    logic [1:0] src;
    logic       ch;   // 0 = left, 1 = right
  } slot_sel_t;

  // Extracts the selector for slot k from a packed slot map.
  function automatic slot_sel_t slot_sel(input logic [C_MAP_W-1:0] map, input int k);
    return slot_sel_t'(map[k*C_SEL_W +: C_SEL_W]);
  endfunction

endpackage

// File: rtl/tdm_src_buffer.sv
// One stereo source: latest left/right pair, fresh flag, and the sticky
// overrun/underrun status for that source.
module tdm_src_buffer #(
  parameter int G_BITS = 16
) (
  input  logic              in_mclk,
  input  logic              in_reset,
  input  logic              in_strobe,
  input  logic              in_tick,
  input  logic              in_clear,
  input  logic [G_BITS-1:0] in_left,
  input  logic [G_BITS-1:0] in_right,
  output logic [G_BITS-1:0] out_left,
  output logic [G_BITS-1:0] out_right,
  output logic              out_overrun,
  output logic              out_underrun
);

  logic fresh;
  logic set_overrun;
  logic set_underrun;

  // A capture landing on the tick is not an overrun: the tick consumes the
  // previous sample and the new one becomes fresh for the next frame.
  assign set_overrun  = in_strobe & fresh & ~in_tick;
  assign set_underrun = in_tick & ~fresh;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge in_mclk) begin
    if (in_reset) begin
      out_left     <= '0;
      out_right    <= '0;
      fresh        <= 1'b0;
      out_overrun  <= 1'b0;
      out_underrun <= 1'b0;
    end else begin
      if (in_strobe) begin
        out_left  <= in_left;
        out_right <= in_right;
      end
      fresh        <= in_strobe | (fresh & ~in_tick);
      // Set has priority over clear so an event coincident with a clear is kept.
      out_overrun  <= set_overrun  | (out_overrun  & ~in_clear);
      out_underrun <= set_underrun | (out_underrun & ~in_clear);
    end
  end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Frame timer, shadow slot map and output mux that assemble 8 TDM slot words
// from up to four stereo sources once per frame.
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int G_BITS      = 16,
  parameter int G_SOURCES   = 4,
  parameter int G_FRAME_DIV = 256
) (
  input  logic                          in_mclk,
  input  logic                          in_reset,
  input  logic [G_SOURCES*G_BITS-1:0]   in_frame_left,
  input  logic [G_SOURCES*G_BITS-1:0]   in_frame_right,
  input  logic [G_SOURCES-1:0]          in_frame_strobe,
  input  logic [C_MAP_W-1:0]            in_slot_map,
  input  logic [C_TDM_SLOTS-1:0]        in_slot_enable,
  input  logic                          in_clear_status,
  output logic [C_TDM_SLOTS*G_BITS-1:0] out_frames,
  output logic                          out_frame_strobe,
  output logic [G_SOURCES-1:0]          out_overrun,
  output logic [G_SOURCES-1:0]          out_underrun
);

  localparam int C_CNT_W = $clog2(G_FRAME_DIV);

  typedef logic [G_BITS-1:0] sample_t;

  logic [C_CNT_W-1:0]            count;
  logic                          tick;
  sample_t                       hold_l [G_SOURCES];
  sample_t                       hold_r [G_SOURCES];
  logic [C_MAP_W-1:0]            shadow_map;
  logic [C_TDM_SLOTS-1:0]        shadow_en;
  logic [C_MAP_W-1:0]            sel_map;
  logic [C_TDM_SLOTS-1:0]        sel_en;
  logic [C_TDM_SLOTS*G_BITS-1:0] frames_next;

  always_ff @(posedge in_mclk) begin
    if (in_reset)  count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

  assign tick = (count == C_CNT_W'(G_FRAME_DIV - 1));

  for (genvar s = 0; s < G_SOURCES; s++) begin : g_src
    tdm_src_buffer #(.G_BITS(G_BITS)) u_buf (
      .in_mclk      (in_mclk),
      .in_reset     (in_reset),
      .in_strobe    (in_frame_strobe[s]),
      .in_tick      (tick),
      .in_clear     (in_clear_status),
      .in_left      (in_frame_left[s*G_BITS +: G_BITS]),
      .in_right     (in_frame_right[s*G_BITS +: G_BITS]),
      .out_left     (hold_l[s]),
      .out_right    (hold_r[s]),
      .out_overrun  (out_overrun[s]),
      .out_underrun (out_underrun[s])
    );
  end

  // On the tick the live map is the one being shadowed, so it drives the mux
  // directly and a map change lands on the frame it is copied with.
  assign sel_map = tick ? in_slot_map    : shadow_map;
  assign sel_en  = tick ? in_slot_enable : shadow_en;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_sel_t sel;
    frames_next = '0;
    sel         = '0;
    for (int k = 0; k < C_TDM_SLOTS; k++) begin
      sel = slot_sel(sel_map, k);
      // Source indices with no instance never match and leave the word zero.
      for (int s = 0; s < G_SOURCES; s++) begin
        if (sel_en[k] && (int'(sel.src) == s)) begin
          frames_next[k*G_BITS +: G_BITS] = sel.ch ? hold_r[s] : hold_l[s];
        end
      end
    end
  end

  always_ff @(posedge in_mclk) begin
    if (in_reset) begin
      shadow_map       <= '0;
      shadow_en        <= '0;
      out_frames       <= '0;
      out_frame_strobe <= 1'b0;
    end else begin
      out_frame_strobe <= tick;
      if (tick) begin
        shadow_map <= in_slot_map;
        shadow_en  <= in_slot_enable;
        out_frames <= frames_next;
      end
    end
  end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Self-checking bench for tdm_slot_scheduler: directed table, hand-written
// corner sequences and randomized traffic against a frame-level model.
module tb_tdm_slot_scheduler;

  localparam int B   = 16;
  localparam int S   = 4;
  localparam int DIV = 256;
  localparam logic [23:0] MAP_ID = 24'hFAC688;

  logic           clk = 1'b0;
  logic           rst;
  logic [S*B-1:0] fl, fr;
  logic [S-1:0]   fs;
  logic [23:0]    map;
  logic [7:0]     en;
  logic           clr;
  logic [8*B-1:0] frames;
  logic           fstb;
  logic [S-1:0]   ov, un;

  int n_vec = 0;
  int n_err = 0;

  tdm_slot_scheduler #(.G_BITS(B), .G_SOURCES(S), .G_FRAME_DIV(DIV)) dut (
    .in_mclk          (clk),
    .in_reset         (rst),
    .in_frame_left    (fl),
    .in_frame_right   (fr),
    .in_frame_strobe  (fs),
    .in_slot_map      (map),
    .in_slot_enable   (en),
    .in_clear_status  (clr),
    .out_frames       (frames),
    .out_frame_strobe (fstb),
    .out_overrun      (ov),
    .out_underrun     (un)
  );

  always #5 clk = ~clk;

  // Frame-level reference state: cycle position in frame, latest samples,
  // freshness per source, sticky flags and the last emitted frame.
  int          m_cnt;
  logic [15:0] m_l [S];
  logic [15:0] m_r [S];
  bit          m_fresh [S];
  logic [S-1:0] m_ov, m_un;
  logic [127:0] m_frames;
  logic         m_stb;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    int src, ch;
    if (rst) begin
      m_cnt = 0; m_ov = '0; m_un = '0; m_frames = '0; m_stb = 1'b0;
      for (int s = 0; s < S; s++) begin m_l[s] = '0; m_r[s] = '0; m_fresh[s] = 0; end
      return;
    end
    tick = (m_cnt == DIV - 1);
    if (tick) begin
      for (int k = 0; k < 8; k++) begin
        src = (map >> (3*k + 1)) & 3;
        ch  = (map >> (3*k)) & 1;
        if (en[k] && src < S) m_frames[k*16 +: 16] = ch ? m_r[src] : m_l[src];
        else                  m_frames[k*16 +: 16] = 16'h0;
      end
    end
    m_stb = tick;
    for (int s = 0; s < S; s++) begin
      bool_flags(s, tick);
      if (fs[s]) begin
        m_l[s] = fl[s*B +: B];
        m_r[s] = fr[s*B +: B];
        m_fresh[s] = 1;
      end else if (tick) begin
        m_fresh[s] = 0;
      end
    end
    m_cnt = (m_cnt + 1) % DIV;
  endtask

  task automatic bool_flags(input int s, input bit tick);
    bit ev_ov, ev_un;
    ev_ov = fs[s] && m_fresh[s] && !tick;
    ev_un = tick && !m_fresh[s];
    m_ov[s] = ev_ov ? 1'b1 : (clr ? 1'b0 : m_ov[s]);
    m_un[s] = ev_un ? 1'b1 : (clr ? 1'b0 : m_un[s]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("strobe",   {127'h0, fstb}, {127'h0, m_stb});
    check("overrun",  {124'h0, ov},   {124'h0, m_ov});
    check("underrun", {124'h0, un},   {124'h0, m_un});
    check("frames",   frames,         m_frames);
    fs  = '0;
    clr = 1'b0;
  endtask

  task automatic run_to(input int c);
    int guard = 0;
    while (m_cnt != c && guard < 2*DIV) begin
      step();
      guard++;
    end
    if (guard >= 2*DIV) begin
      n_err++;
      $display("FAIL run_to: frame position %0d not reached, at %0d", c, m_cnt);
    end
  endtask

  task automatic put(input int s, input logic [15:0] l, input logic [15:0] r);
    fs[s] = 1'b1;
    fl[s*B +: B] = l;
    fr[s*B +: B] = r;
  endtask

  task automatic clear_at_frame_start();
    run_to(1);
    clr = 1'b1;
    step();
  endtask

  typedef struct {
    logic [3:0]   mask;
    logic [15:0]  lbase;
    logic [15:0]  rbase;
    logic [23:0]  map;
    logic [7:0]   en;
    logic [127:0] exp_frames;
    logic [3:0]   exp_ov;
    logic [3:0]   exp_un;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_edges;

    vecs[0] = '{4'hF, 16'h1000, 16'h2000, MAP_ID, 8'hFF,
                {16'h2003, 16'h1003, 16'h2002, 16'h1002, 16'h2001, 16'h1001, 16'h2000, 16'h1000},
                4'h0, 4'h0};
    vecs[1] = '{4'b0101, 16'h3000, 16'h4000, MAP_ID, 8'h0F,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h2001, 16'h1001, 16'h4000, 16'h3000},
                4'h0, 4'b1010};
    vecs[2] = '{4'hF, 16'h5000, 16'h6000, 24'hB6DB6D, 8'hFF,
                {8{16'h6002}}, 4'h0, 4'h0};
    vecs[3] = '{4'hF, 16'h7000, 16'h8000, 24'hDE54C1, 8'hFF,
                {16'h7003, 16'h8003, 16'h7002, 16'h8002, 16'h7001, 16'h8001, 16'h7000, 16'h8000},
                4'h0, 4'h0};

    rst = 1'b1; fl = '0; fr = '0; fs = '0; map = '0; en = '0; clr = 1'b0;
    // Reset held across more than a frame: no strobe may appear meanwhile.
    for (int i = 0; i < DIV + 8; i++) step();
    rst = 1'b0;

    // Reset then idle.
    n_edges = 0;
    while (fstb !== 1'b1 && n_edges < 300) begin
      step();
      n_edges++;
    end
    check("first_strobe_edge", n_edges, DIV);
    check("idle_frames", frames, 128'h0);
    check("idle_underrun", {124'h0, un}, 128'hF);

    // Table of single-frame scenarios.
    for (int i = 0; i < 4; i++) begin
      clear_at_frame_start();
      for (int s = 0; s < S; s++) begin
        run_to(10 + s);
        if (vecs[i].mask[s]) put(s, vecs[i].lbase + 16'(s), vecs[i].rbase + 16'(s));
        step();
      end
      run_to(50);
      map = vecs[i].map;
      en  = vecs[i].en;
      run_to(0);
      check($sformatf("vec%0d_frames", i), frames, vecs[i].exp_frames);
      check($sformatf("vec%0d_overrun", i), {124'h0, ov}, {124'h0, vecs[i].exp_ov});
      check($sformatf("vec%0d_underrun", i), {124'h0, un}, {124'h0, vecs[i].exp_un});
    end

    // Overrun: source 1 strobed twice in one frame, newer value wins.
    map = MAP_ID; en = 8'hFF;
    clear_at_frame_start();
    run_to(10);
    put(0, 16'h0A00, 16'h0A00); put(1, 16'hA1A1, 16'hA1A1);
    put(2, 16'h0A02, 16'h0A02); put(3, 16'h0A03, 16'h0A03);
    step();
    run_to(20);
    put(1, 16'hB1B1, 16'hB1B1);
    step();
    run_to(0);
    check("overrun_flags", {124'h0, ov}, 128'h2);
    check("overrun_underrun", {124'h0, un}, 128'h0);
    check("overrun_frames", frames,
          {16'h0A03, 16'h0A03, 16'h0A02, 16'h0A02, 16'hB1B1, 16'hB1B1, 16'h0A00, 16'h0A00});

    // Tick collision: capture in the tick cycle is held for the next frame.
    clear_at_frame_start();
    run_to(10);
    put(0, 16'h0BAD, 16'h0BAD); put(1, 16'h0C01, 16'h0C01);
    put(2, 16'h0C02, 16'h0C02); put(3, 16'h0C03, 16'h0C03);
    step();
    run_to(DIV - 1);
    put(0, 16'hCAFE, 16'hCAFE);
    step();
    check("collision_old_frame", frames,
          {16'h0C03, 16'h0C03, 16'h0C02, 16'h0C02, 16'h0C01, 16'h0C01, 16'h0BAD, 16'h0BAD});
    check("collision_no_overrun", {124'h0, ov}, 128'h0);
    clear_at_frame_start();
    run_to(10);
    for (int s = 1; s < S; s++) put(s, 16'h1000 + 16'(s), 16'h2000 + 16'(s));
    step();
    run_to(0);
    check("collision_new_frame", frames,
          {16'h2003, 16'h1003, 16'h2002, 16'h1002, 16'h2001, 16'h1001, 16'hCAFE, 16'hCAFE});
    check("collision_underrun", {124'h0, un}, 128'h0);

    // Map change mid-frame: invisible until the tick, then slot 3 is zero.
    clear_at_frame_start();
    run_to(10);
    for (int s = 0; s < S; s++) put(s, 16'h3300 + 16'(s), 16'h4400 + 16'(s));
    step();
    run_to(100);
    en = 8'hF7;
    step();
    run_to(200);
    check("mapchg_before_tick", frames,
          {16'h2003, 16'h1003, 16'h2002, 16'h1002, 16'h2001, 16'h1001, 16'hCAFE, 16'hCAFE});
    run_to(0);
    check("mapchg_after_tick", frames,
          {16'h4403, 16'h3303, 16'h4402, 16'h3302, 16'h0000, 16'h3301, 16'h4400, 16'h3300});

    // Clear coincident with a new overrun on source 2.
    clear_at_frame_start();
    run_to(5);
    put(3, 16'h0303, 16'h0303);
    step();
    put(3, 16'h0404, 16'h0404);
    step();
    check("clear_pre_overrun3", {124'h0, ov}, 128'h8);
    run_to(10);
    put(2, 16'h0202, 16'h0202);
    step();
    run_to(20);
    put(2, 16'h0222, 16'h0222);
    clr = 1'b1;
    step();
    check("clear_vs_event_ov", {124'h0, ov}, 128'h4);
    check("clear_vs_event_un", {124'h0, un}, 128'h0);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 2999) == 0);
      for (int s = 0; s < S; s++) begin
        if ($urandom_range(0, 149) == 0) put(s, 16'($urandom), 16'($urandom));
      end
      if ($urandom_range(0, 299) == 0) clr = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        map = 24'($urandom);
        en  = 8'($urandom);
      end
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
